// File: rtl/fpga_intc_if.sv
// Register strobe bus and CPU interrupt-acknowledge handshake of the FPGA interrupt controller.
interface fpga_intc_if;
  logic        fpga_stb;
  logic        fpga_we;
  logic        fpga_ack;
  logic [3:0]  fpga_addr;
  logic [7:0]  fpga_data;
  logic [31:0] fpga_odata;
  logic        iack_stb;
  logic [2:0]  iack_level;
  logic        iack_ack;
  logic [7:0]  iack_vec;

  modport master (
    output fpga_stb, fpga_we, fpga_addr, fpga_data, iack_stb, iack_level,
    input  fpga_ack, fpga_odata, iack_ack, iack_vec
  );

  modport slave (
    input  fpga_stb, fpga_we, fpga_addr, fpga_data, iack_stb, iack_level,
    output fpga_ack, fpga_odata, iack_ack, iack_vec
  );
endinterface

// File: rtl/fpga_intc.sv
// Seven-level 68040 interrupt controller: edge-latched requests, mask, IPL encode, IACK vectoring.
// Optional FPGA_INTC_SYNC_EN inserts a two-flop synchronizer in front of the edge detector.
module fpga_intc #(
  parameter logic [7:0] VEC_BASE_RST = 8'h40,
  parameter logic [7:0] SPUR_VEC     = 8'h18
) (
  input  logic             clk,
  input  logic             rst,
  fpga_intc_if.slave       bus,
  input  logic [6:0]       irq_in,
  output logic [2:0]       out_ipl
);

  localparam logic [3:0] ADDR_IPEND  = 4'h4;
  localparam logic [3:0] ADDR_IMASK  = 4'h5;
  localparam logic [3:0] ADDR_ISET   = 4'h6;
  localparam logic [3:0] ADDR_IVBASE = 4'h7;
  localparam logic [3:0] ADDR_ISTAT  = 4'h8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } bus_state_t;

  typedef enum logic {
    I_IDLE = 1'b0,
    I_RESP = 1'b1
  } iack_state_t;

  // Index+1 of the highest set request bit, 0 when none.
  function automatic logic [2:0] prio_level(input logic [6:0] req);
    logic [2:0] lvl;
    lvl = 3'd0;
    for (int i = 0; i < 7; i++) begin
      if (req[i]) begin
        lvl = 3'(i + 1);
      end
    end
    return lvl;
  endfunction

  // One-hot pending bit for a level; level 0 selects nothing.
  function automatic logic [6:0] level_bit(input logic [2:0] level);
    logic [6:0] oh;
    case (level)
      3'd1:    oh = 7'h01;
      3'd2:    oh = 7'h02;
      3'd3:    oh = 7'h04;
      3'd4:    oh = 7'h08;
      3'd5:    oh = 7'h10;
      3'd6:    oh = 7'h20;
      3'd7:    oh = 7'h40;
      default: oh = 7'h00;
    endcase
    return oh;
  endfunction

  logic [6:0]  irq_s;
  logic [6:0]  irq_cap_r;
  logic [6:0]  irq_prev_r;
  logic [6:0]  edge_s;
  logic [6:0]  pending_r;
  logic [6:0]  pending_nxt_s;
  logic [6:0]  set_s;
  logic [6:0]  clr_s;
  logic [6:0]  imask_r;
  logic [7:0]  ivbase_r;
  logic [7:0]  ivbase_nxt_s;
  logic [2:0]  cur_level_s;
  logic [2:0]  ipl_r;
  bus_state_t  bstate_r;
  bus_state_t  bstate_nxt_s;
  iack_state_t istate_r;
  iack_state_t istate_nxt_s;
  logic        acc_s;
  logic        wr_ipend_s;
  logic        wr_imask_s;
  logic        wr_iset_s;
  logic        wr_ivbase_s;
  logic        iack_busy_s;
  logic        iack_start_s;
  logic [2:0]  iack_lvl_r;
  logic        iack_hit_r;
  logic        iack_hit_nxt_s;
  logic [7:0]  rdata_s;
  logic [7:0]  rdata_r;
  logic        fpga_ack_nxt_s;
  logic [31:0] fpga_odata_nxt_s;
  logic        iack_ack_nxt_s;
  logic [7:0]  iack_vec_nxt_s;
  logic        fpga_ack_r;
  logic [31:0] fpga_odata_r;
  logic        iack_ack_r;
  logic [7:0]  iack_vec_r;

`ifdef FPGA_INTC_SYNC_EN
  logic [6:0] sync1_r;
  logic [6:0] sync2_r;

  // Two-flop synchronizer for asynchronous interrupt sources.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 7'h00;
      sync2_r <= 7'h00;
    end else begin
      sync1_r <= irq_in;
      sync2_r <= sync1_r;
    end
  end

  assign irq_s = sync2_r;
`else
  assign irq_s = irq_in;
`endif

  // Edge history; reset loads the live level so sources already high do not fire.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_cap_r  <= irq_s;
      irq_prev_r <= irq_s;
    end else begin
      irq_cap_r  <= irq_s;
      irq_prev_r <= irq_cap_r;
    end
  end

  assign edge_s       = irq_cap_r & ~irq_prev_r;
  assign cur_level_s  = prio_level(pending_r & ~{1'b0, imask_r[5:0]});
  assign iack_busy_s  = (istate_r == I_RESP);
  assign acc_s        = (bstate_r == ST_IDLE) && bus.fpga_stb;
  assign iack_start_s = (istate_r == I_IDLE) && bus.iack_stb;
  assign wr_ipend_s   = acc_s && bus.fpga_we && (bus.fpga_addr == ADDR_IPEND);
  assign wr_imask_s   = acc_s && bus.fpga_we && (bus.fpga_addr == ADDR_IMASK);
  assign wr_iset_s    = acc_s && bus.fpga_we && (bus.fpga_addr == ADDR_ISET);
  assign wr_ivbase_s  = acc_s && bus.fpga_we && (bus.fpga_addr == ADDR_IVBASE);

  // Pending update: sets are OR-ed in after clears so a set always wins.
  always_comb begin
    set_s = edge_s;
    clr_s = 7'h00;
    if (wr_iset_s) begin
      set_s = edge_s | bus.fpga_data[6:0];
    end else begin
      set_s = edge_s;
    end
    if (wr_ipend_s) begin
      clr_s = bus.fpga_data[6:0];
    end else begin
      clr_s = 7'h00;
    end
    if (iack_busy_s && iack_hit_r) begin
      clr_s = clr_s | level_bit(iack_lvl_r);
    end else begin
      clr_s = clr_s;
    end
    pending_nxt_s = (pending_r & ~clr_s) | set_s;
    ivbase_nxt_s  = wr_ivbase_s ? bus.fpga_data : ivbase_r;
  end

  // Software-visible registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_r <= 7'h00;
      imask_r   <= 7'h7F;
      ivbase_r  <= VEC_BASE_RST;
    end else begin
      pending_r <= pending_nxt_s;
      imask_r   <= wr_imask_s ? bus.fpga_data[6:0] : imask_r;
      ivbase_r  <= ivbase_nxt_s;
    end
  end

  // Read data mux, sampled when a read is accepted in IDLE.
  always_comb begin
    rdata_s = 8'h00;
    if (acc_s && !bus.fpga_we) begin
      case (bus.fpga_addr)
        ADDR_IPEND:  rdata_s = {1'b0, pending_r};
        ADDR_IMASK:  rdata_s = {1'b0, imask_r};
        ADDR_IVBASE: rdata_s = ivbase_r;
        ADDR_ISTAT:  rdata_s = {4'b0000, iack_busy_s, cur_level_s};
        default:     rdata_s = 8'h00;
      endcase
    end else begin
      rdata_s = 8'h00;
    end
  end

  // State registers of both FSMs plus captured access/IACK context.
  always_ff @(posedge clk) begin
    if (rst) begin
      bstate_r   <= ST_IDLE;
      istate_r   <= I_IDLE;
      rdata_r    <= 8'h00;
      iack_lvl_r <= 3'd0;
      iack_hit_r <= 1'b0;
    end else begin
      bstate_r   <= bstate_nxt_s;
      istate_r   <= istate_nxt_s;
      rdata_r    <= acc_s ? rdata_s : rdata_r;
      iack_lvl_r <= iack_start_s ? bus.iack_level : iack_lvl_r;
      iack_hit_r <= iack_hit_nxt_s;
    end
  end

  // Next-state logic for the register bus and IACK FSMs.
  always_comb begin
    bstate_nxt_s = bstate_r;
    istate_nxt_s = istate_r;
    case (bstate_r)
      ST_IDLE: bstate_nxt_s = bus.fpga_stb ? ST_WAIT : ST_IDLE;
      ST_WAIT: bstate_nxt_s = ST_ACK;
      ST_ACK:  bstate_nxt_s = ST_IDLE;
      default: bstate_nxt_s = ST_IDLE;
    endcase
    case (istate_r)
      I_IDLE:  istate_nxt_s = bus.iack_stb ? I_RESP : I_IDLE;
      I_RESP:  istate_nxt_s = I_IDLE;
      default: istate_nxt_s = I_IDLE;
    endcase
  end

  // Output decode, one cycle ahead; the IACK lookup sees pending as it will be in I_RESP.
  always_comb begin
    iack_hit_nxt_s   = iack_start_s && ((pending_nxt_s & level_bit(bus.iack_level)) != 7'h00);
    fpga_ack_nxt_s   = (bstate_nxt_s == ST_ACK);
    fpga_odata_nxt_s = 32'h0000_0000;
    iack_ack_nxt_s   = (istate_nxt_s == I_RESP);
    iack_vec_nxt_s   = 8'h00;
    if (fpga_ack_nxt_s) begin
      fpga_odata_nxt_s = {24'h00_0000, rdata_r};
    end else begin
      fpga_odata_nxt_s = 32'h0000_0000;
    end
    if (iack_start_s) begin
      iack_vec_nxt_s = iack_hit_nxt_s ? (ivbase_nxt_s + {5'b00000, bus.iack_level}) : SPUR_VEC;
    end else begin
      iack_vec_nxt_s = 8'h00;
    end
  end

  // Registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      fpga_ack_r   <= 1'b0;
      fpga_odata_r <= 32'h0000_0000;
      iack_ack_r   <= 1'b0;
      iack_vec_r   <= 8'h00;
    end else begin
      fpga_ack_r   <= fpga_ack_nxt_s;
      fpga_odata_r <= fpga_odata_nxt_s;
      iack_ack_r   <= iack_ack_nxt_s;
      iack_vec_r   <= iack_vec_nxt_s;
    end
  end

  // IPL output; frozen during the acknowledge response so the CPU sees a stable level.
  always_ff @(posedge clk) begin
    if (rst) begin
      ipl_r <= 3'b111;
    end else if (iack_busy_s) begin
      ipl_r <= ipl_r;
    end else begin
      ipl_r <= ~cur_level_s;
    end
  end

  assign bus.fpga_ack   = fpga_ack_r;
  assign bus.fpga_odata = fpga_odata_r;
  assign bus.iack_ack   = iack_ack_r;
  assign bus.iack_vec   = iack_vec_r;
  assign out_ipl        = ipl_r;

endmodule

// File: tb/tb_fpga_intc.sv
// Directed bench for fpga_intc; bus and IACK responses are checked by queue-driven monitors.
module tb_fpga_intc;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    bit          chk;
  } bexp_t;

  typedef struct {
    int         cyc;
    logic [7:0] vec;
  } iexp_t;

  logic       clk;
  logic       rst;
  logic [6:0] irq_in;
  logic [2:0] out_ipl;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  bexp_t      bq[$];
  iexp_t      iq[$];
  bexp_t      b_e;
  iexp_t      i_e;

  fpga_intc_if bus();

  fpga_intc #(.VEC_BASE_RST(8'h40), .SPUR_VEC(8'h18)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .irq_in  (irq_in),
    .out_ipl (out_ipl)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_access(input logic we, input logic [3:0] a, input logic [7:0] d,
                            input logic [31:0] exp, input bit chk);
    bexp_t e;
    bus.fpga_stb  = 1'b1;
    bus.fpga_we   = we;
    bus.fpga_addr = a;
    bus.fpga_data = d;
    e.cyc = cyc + 2;
    e.data = exp;
    e.chk = chk;
    bq.push_back(e);
    tick(1);
    bus.fpga_stb = 1'b0;
    tick(2);
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
    bus_access(1'b1, a, d, 32'h0, 1'b0);
  endtask

  task automatic bus_read(input logic [3:0] a, input logic [7:0] exp);
    bus_access(1'b0, a, 8'h00, {24'h0, exp}, 1'b1);
  endtask

  task automatic iack_seq(input logic [2:0] level, input logic [7:0] exp);
    iexp_t e;
    bus.iack_stb   = 1'b1;
    bus.iack_level = level;
    e.cyc = cyc + 1;
    e.vec = exp;
    iq.push_back(e);
    tick(1);
    bus.iack_stb = 1'b0;
    tick(2);
  endtask

  // Scoreboard monitors: every ack pops one expectation and checks timing and data.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.fpga_ack === 1'b1) begin
        if (bq.size() == 0) begin
          check("bus_ack_unexpected", 32'd1, 32'd0);
        end else begin
          b_e = bq.pop_front();
          check("bus_ack_cycle", cyc, b_e.cyc);
          if (b_e.chk) check("bus_rdata", bus.fpga_odata, b_e.data);
        end
      end
      if (bus.iack_ack === 1'b1) begin
        if (iq.size() == 0) begin
          check("iack_ack_unexpected", 32'd1, 32'd0);
        end else begin
          i_e = iq.pop_front();
          check("iack_cycle", cyc, i_e.cyc);
          check("iack_vec", {24'h0, bus.iack_vec}, {24'h0, i_e.vec});
        end
      end
    end
  end

  initial begin
    bexp_t e;
    rst = 1'b1;
    irq_in = 7'h00;
    bus.fpga_stb = 1'b0;
    bus.fpga_we = 1'b0;
    bus.fpga_addr = 4'h0;
    bus.fpga_data = 8'h00;
    bus.iack_stb = 1'b0;
    bus.iack_level = 3'd0;
    tick(3);
    check("rst_ipl", out_ipl, 3'b111);
    check("rst_ack", bus.fpga_ack, 1'b0);
    check("rst_odata", bus.fpga_odata, 32'h0);
    check("rst_iack_ack", bus.iack_ack, 1'b0);
    check("rst_iack_vec", bus.iack_vec, 8'h00);
    rst = 1'b0;
    tick(1);
    bus_read(4'h5, 8'h7F);
    bus_read(4'h7, 8'h40);
    bus_read(4'h4, 8'h00);
    bus_read(4'h8, 8'h00);

    // Unmasked level 3 request and its two-cycle latency.
    bus_write(4'h5, 8'h00);
    irq_in = 7'h04;
    tick(1);
    irq_in = 7'h00;
    tick(1);
    check("lvl3_latency", out_ipl, 3'b111);
    tick(1);
    check("lvl3_ipl", out_ipl, 3'b100);
    bus_read(4'h4, 8'h04);
    bus_write(4'h4, 8'h04);
    check("lvl3_cleared_ipl", out_ipl, 3'b111);

    // Full mask: only level 7 gets through.
    bus_write(4'h5, 8'h7F);
    irq_in = 7'h41;
    tick(1);
    irq_in = 7'h00;
    tick(2);
    check("nmi_ipl", out_ipl, 3'b000);
    bus_write(4'h4, 8'h40);
    check("nmi_cleared_ipl", out_ipl, 3'b111);
    bus_read(4'h4, 8'h01);
    bus_write(4'h4, 8'h01);

    // IACK of level 5 with levels 3 and 5 pending; ISTAT read while busy.
    bus_write(4'h5, 8'h00);
    bus_write(4'h6, 8'h14);
    check("lvl5_ipl", out_ipl, 3'b010);
    bus_read(4'h8, 8'h05);
    bus.iack_stb = 1'b1;
    bus.iack_level = 3'd5;
    i_e.cyc = cyc + 1;
    i_e.vec = 8'h45;
    iq.push_back(i_e);
    tick(1);
    bus.iack_stb = 1'b0;
    bus.fpga_stb = 1'b1;
    bus.fpga_we = 1'b0;
    bus.fpga_addr = 4'h8;
    e.cyc = cyc + 2;
    e.data = 32'h0D;
    e.chk = 1'b1;
    bq.push_back(e);
    check("iack_hold_ipl0", out_ipl, 3'b010);
    tick(1);
    bus.fpga_stb = 1'b0;
    check("iack_hold_ipl1", out_ipl, 3'b010);
    tick(1);
    check("iack_after_ipl", out_ipl, 3'b100);
    tick(1);
    check("idle_odata", bus.fpga_odata, 32'h0);
    check("idle_iack_vec", bus.iack_vec, 8'h00);
    bus_read(4'h4, 8'h04);

    // Spurious acknowledges leave pending untouched; a real one clears.
    bus_write(4'h4, 8'h7F);
    bus_write(4'h6, 8'h01);
    iack_seq(3'd0, 8'h18);
    iack_seq(3'd2, 8'h18);
    bus_read(4'h4, 8'h01);
    iack_seq(3'd1, 8'h41);
    bus_read(4'h4, 8'h00);

    // Vector arithmetic wraps at 8 bits.
    bus_write(4'h7, 8'hFE);
    bus_write(4'h6, 8'h40);
    iack_seq(3'd7, 8'h05);
    bus_read(4'h4, 8'h00);
    bus_read(4'h7, 8'hFE);
    bus_write(4'h7, 8'h40);

    // Edge-set and IPEND clear land on the same edge: set wins.
    irq_in = 7'h02;
    tick(1);
    irq_in = 7'h00;
    bus_write(4'h4, 8'h02);
    bus_read(4'h4, 8'h02);
    check("set_wins_ipl", out_ipl, 3'b101);
    bus_write(4'h4, 8'h02);

    // Unmapped read, with a second strobe during WAIT that must be ignored.
    bus.fpga_stb = 1'b1;
    bus.fpga_we = 1'b0;
    bus.fpga_addr = 4'h3;
    e.cyc = cyc + 2;
    e.data = 32'h0;
    e.chk = 1'b1;
    bq.push_back(e);
    tick(2);
    bus.fpga_stb = 1'b0;
    tick(3);

    // IACK strobe held into I_RESP gives a single response.
    bus_write(4'h6, 8'h08);
    bus.iack_stb = 1'b1;
    bus.iack_level = 3'd4;
    i_e.cyc = cyc + 1;
    i_e.vec = 8'h44;
    iq.push_back(i_e);
    tick(2);
    bus.iack_stb = 1'b0;
    tick(3);
    bus_read(4'h4, 8'h00);

    // Reset during an access aborts it; a source high through reset raises nothing.
    bus_write(4'h6, 8'h40);
    check("pre_abort_ipl", out_ipl, 3'b000);
    bus.fpga_stb = 1'b1;
    bus.fpga_we = 1'b0;
    bus.fpga_addr = 4'h5;
    tick(1);
    bus.fpga_stb = 1'b0;
    rst = 1'b1;
    irq_in = 7'h08;
    tick(1);
    check("abort_ipl", out_ipl, 3'b111);
    check("abort_ack", bus.fpga_ack, 1'b0);
    tick(1);
    rst = 1'b0;
    tick(2);
    bus_read(4'h5, 8'h7F);
    bus_read(4'h4, 8'h00);
    bus_read(4'h7, 8'h40);
    irq_in = 7'h00;
    tick(4);
    check("bus_queue_empty", bq.size(), 32'd0);
    check("iack_queue_empty", iq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
